// File: rtl/fantasticfft_fft8_loader_if.sv
// ---------------------------------------------------------------------------
// fantasticfft_fft8_loader_if
// Sample stream feeding the 8-point FFT loader.
//   s_data  : signed fixed-point sample, [INT_SIZE-1:-FRAC_SIZE]
//   s_valid : s_data holds a sample
//   s_ready : loader accepts a sample this cycle
//   flush   : zero-pad and emit the partial frame being collected
// Modports: master = sample source, slave = loader.
// ---------------------------------------------------------------------------
interface fantasticfft_fft8_loader_if #(
   parameter int INT_SIZE  = 8,
   parameter int FRAC_SIZE = 8
);
   logic signed [INT_SIZE-1:-FRAC_SIZE] s_data;
   logic                                s_valid;
   logic                                s_ready;
   logic                                flush;

   modport master (output s_data, output s_valid, output flush, input s_ready);
   modport slave  (input s_data, input s_valid, input flush, output s_ready);
endinterface

// File: rtl/fantasticfft_fft8_loader.sv
// ---------------------------------------------------------------------------
// fantasticfft_fft8_loader
// Serial-to-parallel front end for the 8-point FFT. Collects eight samples
// from a valid/ready stream into a fill buffer and presents the whole frame
// on x0..x7 with a one-cycle frame_valid pulse. flush zero-pads a partial
// frame so trailing samples still reach the FFT.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   s_if (slave)  : s_data / s_valid / s_ready / flush sample stream
//   x0..x7        : frame samples, held stable between frames
//   frame_valid   : one-cycle pulse per emitted frame
//   frame_padded  : current frame on x0..x7 contains zero padding
//   frame_count   : emitted frames, wraps at 16 bits
// ---------------------------------------------------------------------------
module fantasticfft_fft8_loader #(
   parameter int INT_SIZE  = 8,
   parameter int FRAC_SIZE = 8,
   parameter int BITREV    = 0
) (
   input  logic                                clk,
   input  logic                                rst_n,
   fantasticfft_fft8_loader_if.slave           s_if,
   output logic signed [INT_SIZE-1:-FRAC_SIZE] x0,
   output logic signed [INT_SIZE-1:-FRAC_SIZE] x1,
   output logic signed [INT_SIZE-1:-FRAC_SIZE] x2,
   output logic signed [INT_SIZE-1:-FRAC_SIZE] x3,
   output logic signed [INT_SIZE-1:-FRAC_SIZE] x4,
   output logic signed [INT_SIZE-1:-FRAC_SIZE] x5,
   output logic signed [INT_SIZE-1:-FRAC_SIZE] x6,
   output logic signed [INT_SIZE-1:-FRAC_SIZE] x7,
   output logic                                frame_valid,
   output logic                                frame_padded,
   output logic [15:0]                         frame_count
);

   typedef logic signed [INT_SIZE-1:-FRAC_SIZE] sample_t;
   typedef enum logic {FILL, PAD} state_t;

   state_t     r_state;
   logic [2:0] r_idx;
   sample_t    r_buf [8];
   sample_t    r_x   [8];
   logic       r_frame_valid;
   logic       r_frame_padded;
   logic [15:0] r_frame_count;

   logic       w_wr;
   sample_t    w_wr_data;
   sample_t    w_buf [8];
   logic       w_last;
   logic [2:0] w_idx_nxt;

   // Buffer slot that feeds output position j.
   function automatic logic [2:0] out_slot(input logic [2:0] j);
      if (BITREV != 0) return {j[0], j[1], j[2]};
      else             return j;
   endfunction

   assign s_if.s_ready = (r_state == FILL);

   // w_buf is the buffer as it will look after this cycle's write, so the
   // emitting edge can load x with the slot-7 sample written in the same cycle.
   always_comb begin
      w_wr      = 1'b0;
      w_wr_data = '0;
      if (r_state == FILL) begin
         w_wr      = s_if.s_valid;
         w_wr_data = s_if.s_data;
      end else begin
         w_wr      = 1'b1;
         w_wr_data = '0;
      end
      w_buf = r_buf;
      if (w_wr) w_buf[r_idx] = w_wr_data;
      w_last    = w_wr && (r_idx == 3'd7);
      w_idx_nxt = w_wr ? r_idx + 3'd1 : r_idx;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state        <= FILL;
         r_idx          <= 3'd0;
         r_frame_valid  <= 1'b0;
         r_frame_padded <= 1'b0;
         r_frame_count  <= 16'd0;
         for (int j = 0; j < 8; j++) begin
            r_buf[j] <= '0;
            r_x[j]   <= '0;
         end
      end else begin
         r_frame_valid <= 1'b0;
         if (w_wr) begin
            r_buf[r_idx] <= w_wr_data;
            r_idx        <= w_idx_nxt;
         end
         if (w_last) begin
            for (int j = 0; j < 8; j++) r_x[j] <= w_buf[out_slot(3'(j))];
            r_frame_valid  <= 1'b1;
            r_frame_padded <= (r_state == PAD);
            r_frame_count  <= r_frame_count + 16'd1;
            r_state        <= FILL;
         end else if ((r_state == FILL) && s_if.flush && (w_idx_nxt != 3'd0)) begin
            // A completing sample takes priority over flush (handled above);
            // an empty buffer never produces a padded frame.
            r_state <= PAD;
         end
      end
   end

   assign x0           = r_x[0];
   assign x1           = r_x[1];
   assign x2           = r_x[2];
   assign x3           = r_x[3];
   assign x4           = r_x[4];
   assign x5           = r_x[5];
   assign x6           = r_x[6];
   assign x7           = r_x[7];
   assign frame_valid  = r_frame_valid;
   assign frame_padded = r_frame_padded;
   assign frame_count  = r_frame_count;

endmodule

// File: tb/tb_fantasticfft_fft8_loader.sv
// ---------------------------------------------------------------------------
// tb_fantasticfft_fft8_loader
// Drives identical stimulus into a BITREV=0 and a BITREV=1 loader and checks
// both against a queue-based frame model.
// ---------------------------------------------------------------------------
module tb_fantasticfft_fft8_loader;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fantasticfft_fft8_loader_if #(.INT_SIZE(8), .FRAC_SIZE(8)) if_a ();
   fantasticfft_fft8_loader_if #(.INT_SIZE(8), .FRAC_SIZE(8)) if_b ();

   logic [15:0] xa [8];
   logic [15:0] xb [8];
   logic        fv_a, fv_b, pad_a, pad_b;
   logic [15:0] cnt_a, cnt_b;

   fantasticfft_fft8_loader #(.INT_SIZE(8), .FRAC_SIZE(8), .BITREV(0)) dut_a (
      .clk(clk), .rst_n(rst_n), .s_if(if_a),
      .x0(xa[0]), .x1(xa[1]), .x2(xa[2]), .x3(xa[3]),
      .x4(xa[4]), .x5(xa[5]), .x6(xa[6]), .x7(xa[7]),
      .frame_valid(fv_a), .frame_padded(pad_a), .frame_count(cnt_a));

   fantasticfft_fft8_loader #(.INT_SIZE(8), .FRAC_SIZE(8), .BITREV(1)) dut_b (
      .clk(clk), .rst_n(rst_n), .s_if(if_b),
      .x0(xb[0]), .x1(xb[1]), .x2(xb[2]), .x3(xb[3]),
      .x4(xb[4]), .x5(xb[5]), .x6(xb[6]), .x7(xb[7]),
      .frame_valid(fv_b), .frame_padded(pad_b), .frame_count(cnt_b));

   // Output position j of the bit-reversed loader shows frame sample BR[j].
   localparam int BR [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

   int total = 0;
   int bad   = 0;

   // Reference model: samples collected so far, padding flag, last frame.
   logic [15:0] mq [$];
   bit          m_pad;
   logic [15:0] m_x [8];
   bit          m_fv;
   bit          m_padded;
   logic [15:0] m_cnt;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_outs();
      for (int j = 0; j < 8; j++) begin
         chk($sformatf("xa%0d", j), xa[j], m_x[j]);
         chk($sformatf("xb%0d", j), xb[j], m_x[BR[j]]);
      end
      chk("frame_valid_a", {15'd0, fv_a}, {15'd0, m_fv});
      chk("frame_valid_b", {15'd0, fv_b}, {15'd0, m_fv});
      chk("frame_padded_a", {15'd0, pad_a}, {15'd0, m_padded});
      chk("frame_padded_b", {15'd0, pad_b}, {15'd0, m_padded});
      chk("frame_count_a", cnt_a, m_cnt);
      chk("frame_count_b", cnt_b, m_cnt);
   endtask

   task automatic drive(input bit v, input logic [15:0] d, input bit f);
      if_a.s_valid = v; if_a.s_data = d; if_a.flush = f;
      if_b.s_valid = v; if_b.s_data = d; if_b.flush = f;
   endtask

   // One clock cycle: drive inputs, check s_ready, advance model, check outputs.
   task automatic step(input bit v, input logic [15:0] d, input bit f);
      bit was_pad;
      @(negedge clk);
      drive(v, d, f);
      #1;
      chk("s_ready_a", {15'd0, if_a.s_ready}, {15'd0, !m_pad});
      chk("s_ready_b", {15'd0, if_b.s_ready}, {15'd0, !m_pad});
      was_pad = m_pad;
      if (m_pad)  mq.push_back(16'h0000);
      else if (v) mq.push_back(d);
      m_fv = 1'b0;
      if (mq.size() == 8) begin
         for (int k = 0; k < 8; k++) m_x[k] = mq[k];
         m_padded = was_pad;
         m_cnt    = m_cnt + 16'd1;
         m_fv     = 1'b1;
         mq.delete();
         m_pad    = 1'b0;
      end else if (!was_pad && f && mq.size() != 0) begin
         m_pad = 1'b1;
      end
      @(posedge clk);
      #1;
      check_outs();
   endtask

   task automatic do_reset();
      @(negedge clk);
      drive(1'b0, 16'h0000, 1'b0);
      rst_n = 1'b0;
      #1;
      mq.delete();
      m_pad = 1'b0; m_fv = 1'b0; m_padded = 1'b0; m_cnt = 16'd0;
      for (int k = 0; k < 8; k++) m_x[k] = 16'h0000;
      check_outs();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      logic [15:0] sum;
      drive(1'b0, 16'h0000, 1'b0);
      do_reset();

      // Continuous stream 1.0..8.0
      for (int i = 1; i <= 8; i++) step(1'b1, 16'(i * 256), 1'b0);
      chk("cont_x0", xa[0], 16'h0100);
      chk("cont_x7", xa[7], 16'h0800);
      chk("cont_count", cnt_a, 16'd1);

      // Gapped stream, 16 samples
      for (int i = 0; i < 16; i++) begin
         step(1'b1, 16'(16'h1000 + i), 1'b0);
         step(1'b0, 16'hDEAD, 1'b0);
      end
      chk("gap_count", cnt_a, 16'd3);
      chk("gap_x7", xa[7], 16'h100F);

      // Flush after 3 samples; valid stays high during padding (must be ignored)
      step(1'b1, 16'h0100, 1'b0);
      step(1'b1, 16'hFF00, 1'b0);
      step(1'b1, 16'h0080, 1'b0);
      step(1'b0, 16'h0000, 1'b1);
      for (int i = 0; i < 5; i++) step(1'b1, 16'h7777, 1'b1);
      chk("flush_x1", xa[1], 16'hFF00);
      chk("flush_x3", xa[3], 16'h0000);
      chk("flush_padded", {15'd0, pad_a}, 16'd1);

      // Flush together with the 8th sample, then flush with empty buffer
      for (int i = 0; i < 7; i++) step(1'b1, 16'(16'h2000 + i), 1'b0);
      step(1'b1, 16'h2007, 1'b1);
      chk("flush8_padded", {15'd0, pad_a}, 16'd0);
      step(1'b0, 16'h0000, 1'b1);
      step(1'b0, 16'h0000, 1'b0);
      chk("flush8_count", cnt_a, 16'd5);

      // Samples 0..7 for the bit-reversed ordering
      for (int i = 0; i < 8; i++) step(1'b1, 16'(i * 256), 1'b0);
      chk("br_x1", xb[1], 16'h0400);
      chk("br_x3", xb[3], 16'h0600);
      chk("br_x4", xb[4], 16'h0100);
      chk("br_x6", xb[6], 16'h0300);

      // Reset after 5 samples, then 8 fresh samples
      for (int i = 0; i < 5; i++) step(1'b1, 16'(16'h3000 + i), 1'b0);
      do_reset();
      for (int i = 0; i < 8; i++) step(1'b1, 16'(16'h4000 + i), 1'b0);
      chk("rst_count", cnt_a, 16'd1);
      chk("rst_x0", xa[0], 16'h4000);

      // Frame of 1.0 as the FFT would see it: DC term is the sum, 8.0
      for (int i = 0; i < 8; i++) step(1'b1, 16'h0100, 1'b0);
      sum = 16'h0000;
      for (int j = 0; j < 8; j++) sum = sum + xa[j];
      chk("fft_dc_sum", sum, 16'h0800);

      // Randomized traffic
      for (int i = 0; i < 400; i++)
         step($urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 19) == 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
